syn_downcount: RTL and testbench

Synchronous, parameterised, auto-reloading down counter built from per-bit toggle stages. It is the decrementing counterpart of the lab's synchronous up counter. It adds a parallel load, a count enable, a zero flag and a one-cycle borrow pulse on wrap. Lab designs use it as a programmable divider or timeout timer that re-arms itself from a captured reload value.

---
 rtl/syn_downcount_if.sv | 22 ++
 rtl/syn_downcount.sv | 60 ++++++
 tb/tb_syn_downcount.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/syn_downcount_if.sv
// Control and status bundle for the auto-reloading down counter.
// The master drives en/load/d; the counter (slave) returns q/zero/borrow.
interface syn_downcount_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             zero;
   logic             borrow;

   modport master (
      output en, load, d,
      input  q, zero, borrow
   );

   modport slave (
      input  en, load, d,
      output q, zero, borrow
   );
endinterface

// File: rtl/syn_downcount.sv
// Auto-reloading down counter built from per-bit toggle stages.
// It has a parallel load that also captures the reload value, and a one-cycle borrow on wrap.
module syn_downcount #(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   syn_downcount_if.slave bus
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] rld_r;
   logic             borrow_r;
   logic [WIDTH-1:0] tgl_dec;
   logic [WIDTH-1:0] tgl;
   logic             q_zero;

   assign q_zero     = (q_r == '0);
   assign bus.q      = q_r;
   assign bus.zero   = q_zero;
   assign bus.borrow = borrow_r;

   // Decrement ripple: bit i flips only when every lower bit is already 0.
   always_comb begin
      tgl_dec    = '0;
      tgl_dec[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         tgl_dec[i] = tgl_dec[i-1] & ~q_r[i-1];
      end
   end

   // Load and reload reuse the toggle path by toggling toward the target value.
   always_comb begin
      tgl = '0;
      if (bus.load) begin
         tgl = q_r ^ bus.d;
      end else if (bus.en) begin
         if (q_zero) begin
            tgl = q_r ^ rld_r;
         end else begin
            tgl = tgl_dec;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r      <= '0;
         rld_r    <= '1;
         borrow_r <= 1'b0;
      end else begin
         q_r      <= q_r ^ tgl;
         borrow_r <= ~bus.load & bus.en & q_zero;
         if (bus.load) begin
            rld_r <= bus.d;
         end
      end
   end

endmodule

// File: tb/tb_syn_downcount.sv
// Randomised and directed bench for syn_downcount.
// The reference model is plain arithmetic on the count and reload values.
module tb_syn_downcount;
   localparam int WIDTH = 4;
   localparam int unsigned MAXV = (1 << WIDTH) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   syn_downcount_if #(.WIDTH(WIDTH)) bus ();
   syn_downcount #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned q_m   = 0;
   int unsigned rld_m = MAXV;
   bit          b_m   = 1'b0;

   function automatic logic [WIDTH+1:0] expv();
      logic [WIDTH-1:0] qv;
      qv = q_m[WIDTH-1:0];
      return {qv, (q_m == 0), b_m};
   endfunction

   task automatic model_reset();
      q_m   = 0;
      rld_m = MAXV;
      b_m   = 1'b0;
   endtask

   // Drive inputs, take one edge, advance the model, land 1 ns after the edge.
   task automatic step(input bit en, input bit ld, input int unsigned dv);
      int unsigned dm;
      dm       = dv & MAXV;
      bus.en   = en;
      bus.load = ld;
      bus.d    = dm[WIDTH-1:0];
      @(posedge clk);
      if (reset) begin
         if (ld) begin
            q_m = dm; rld_m = dm; b_m = 1'b0;
         end else if (en) begin
            if (q_m == 0) begin
               q_m = rld_m; b_m = 1'b1;
            end else begin
               q_m = q_m - 1; b_m = 1'b0;
            end
         end else begin
            b_m = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      bus.en = 1'b1; bus.load = 1'b0; bus.d = '0;
      #2;
      n_checks++;
      if ({bus.q, bus.zero, bus.borrow} !== {{WIDTH{1'b0}}, 2'b10}) begin
         n_fail++;
         $display("FAIL reset_state: q=%0d zero=%0b borrow=%0b, expected q=0 zero=1 borrow=0",
                  bus.q, bus.zero, bus.borrow);
      end
      repeat (2) step(1'b1, 1'b1, 7);
      n_checks++;
      if ({bus.q, bus.zero, bus.borrow} !== {{WIDTH{1'b0}}, 2'b10}) begin
         n_fail++;
         $display("FAIL reset_dominates: q=%0d zero=%0b borrow=%0b, expected q=0 zero=1 borrow=0",
                  bus.q, bus.zero, bus.borrow);
      end
      bus.en = 1'b0; bus.load = 1'b0;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_free_run();
      int nb = 0;
      for (int k = 1; k <= 18; k++) begin
         step(1'b1, 1'b0, 0);
         if (bus.borrow === 1'b1) nb++;
         n_checks++;
         if ({bus.q, bus.zero, bus.borrow} !== expv()) begin
            n_fail++;
            $display("FAIL free_run[%0d]: q=%0d zero=%0b borrow=%0b, expected q=%0d zero=%0b borrow=%0b",
                     k, bus.q, bus.zero, bus.borrow, q_m, (q_m == 0), b_m);
         end
      end
      // 0 -> 15 ... 0 -> 15 ... 14: two wraps in 18 edges
      n_checks++;
      if (nb != 2) begin
         n_fail++;
         $display("FAIL free_run_borrows: count=%0d, expected 2", nb);
      end
   endtask

   task automatic test_load_run();
      int nb = 0;
      step(1'b0, 1'b1, 5);
      n_checks++;
      if (bus.q !== 4'd5 || bus.borrow !== 1'b0) begin
         n_fail++;
         $display("FAIL load5: q=%0d borrow=%0b, expected q=5 borrow=0", bus.q, bus.borrow);
      end
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 0);
         if (bus.borrow === 1'b1) nb++;
         n_checks++;
         if ({bus.q, bus.zero, bus.borrow} !== expv()) begin
            n_fail++;
            $display("FAIL load_run[%0d]: q=%0d zero=%0b borrow=%0b, expected q=%0d zero=%0b borrow=%0b",
                     k, bus.q, bus.zero, bus.borrow, q_m, (q_m == 0), b_m);
         end
         if (k == 6) begin
            n_checks++;
            if (bus.q !== 4'd5 || bus.borrow !== 1'b1) begin
               n_fail++;
               $display("FAIL load_period6: q=%0d borrow=%0b, expected q=5 borrow=1", bus.q, bus.borrow);
            end
         end
      end
      n_checks++;
      if (nb != 1) begin
         n_fail++;
         $display("FAIL load_run_borrows: count=%0d, expected 1", nb);
      end
   endtask

   task automatic test_enable_hold();
      step(1'b0, 1'b1, 9);
      repeat (2) step(1'b1, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 0);
         n_checks++;
         if ({bus.q, bus.zero, bus.borrow} !== {4'd7, 2'b00}) begin
            n_fail++;
            $display("FAIL hold[%0d]: q=%0d zero=%0b borrow=%0b, expected q=7 zero=0 borrow=0",
                     k, bus.q, bus.zero, bus.borrow);
         end
      end
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      n_checks++;
      if (bus.q !== 4'd5 || bus.q !== q_m[WIDTH-1:0]) begin
         n_fail++;
         $display("FAIL hold_resume: q=%0d, expected q=5", bus.q);
      end
   endtask

   task automatic test_load_at_zero();
      step(1'b0, 1'b1, 2);
      repeat (2) step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 3);
      n_checks++;
      if ({bus.q, bus.zero, bus.borrow} !== {4'd3, 2'b00}) begin
         n_fail++;
         $display("FAIL load_at_zero: q=%0d zero=%0b borrow=%0b, expected q=3 zero=0 borrow=0",
                  bus.q, bus.zero, bus.borrow);
      end
      repeat (4) step(1'b1, 1'b0, 0);
      n_checks++;
      if ({bus.q, bus.zero, bus.borrow} !== {4'd3, 2'b01} || bus.q !== q_m[WIDTH-1:0]) begin
         n_fail++;
         $display("FAIL reload_to_3: q=%0d zero=%0b borrow=%0b, expected q=3 zero=0 borrow=1",
                  bus.q, bus.zero, bus.borrow);
      end
   endtask

   task automatic test_divide_by_one();
      step(1'b0, 1'b1, 0);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 0);
         n_checks++;
         if ({bus.q, bus.zero, bus.borrow} !== {4'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL div1[%0d]: q=%0d zero=%0b borrow=%0b, expected q=0 zero=1 borrow=1",
                     k, bus.q, bus.zero, bus.borrow);
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, 1'b1, 9);
      repeat (3) step(1'b1, 1'b0, 0);
      n_checks++;
      if (bus.q !== 4'd6) begin
         n_fail++;
         $display("FAIL pre_reset: q=%0d, expected q=6", bus.q);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.q, bus.zero, bus.borrow} !== {4'd0, 2'b10}) begin
         n_fail++;
         $display("FAIL async_reset: q=%0d zero=%0b borrow=%0b, expected q=0 zero=1 borrow=0",
                  bus.q, bus.zero, bus.borrow);
      end
      model_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      step(1'b1, 1'b0, 0);
      n_checks++;
      if ({bus.q, bus.zero, bus.borrow} !== {4'd15, 2'b01}) begin
         n_fail++;
         $display("FAIL post_reset_reload: q=%0d zero=%0b borrow=%0b, expected q=15 zero=0 borrow=1",
                  bus.q, bus.zero, bus.borrow);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), $urandom_range(0, MAXV));
         n_checks++;
         if ({bus.q, bus.zero, bus.borrow} !== expv()) begin
            n_fail++;
            $display("FAIL random[%0d]: q=%0d zero=%0b borrow=%0b, expected q=%0d zero=%0b borrow=%0b",
                     k, bus.q, bus.zero, bus.borrow, q_m, (q_m == 0), b_m);
         end
      end
   endtask

   initial begin
      bus.en = 1'b0; bus.load = 1'b0; bus.d = '0;
      test_reset();
      test_free_run();
      test_load_run();
      test_enable_hold();
      test_load_at_zero();
      test_divide_by_one();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
